// File: rtl/pkt_dvdr_tx_framer.sv
// Store-and-forward framer: buffers one payload from a valid/ready byte stream, then
// emits |SOP|LEN|D1..Dn|pad|parity|EOP| on tx_en/tx_data with min-length padding and max-length truncation.
module pkt_dvdr_tx_framer #(
  parameter int          MAX_PAYLOAD = 64,
  parameter int          MIN_PAYLOAD = 4,
  parameter logic [7:0]  SOP_BYTE    = 8'hA5,
  parameter logic [7:0]  EOP_BYTE    = 8'h5A,
  parameter logic [7:0]  PAD_BYTE    = 8'h00
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic [7:0] in_data_i,
  input  logic       in_last_i,
  output logic       tx_en_o,
  output logic [7:0] tx_data_o,
  output logic       ovf_err_o
);
  localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;

  typedef enum logic [3:0] {
    S_COLLECT, S_DROP, S_SOP, S_LEN, S_DATA, S_PAD, S_PARITY, S_EOP, S_IDLE_GAP
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] wr_cnt_q, wr_cnt_d;
  logic [7:0] rd_cnt_q, rd_cnt_d;
  logic [7:0] len_q, len_d;
  logic [7:0] parity_q, parity_d;
  logic       tx_en_q, tx_en_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       ovf_q, ovf_d;
  logic [7:0] buf_q [MAX_PAYLOAD];

  logic acc, last_slot, data_done, pad_done, short_pkt;

  // rst_n gates ready so nothing is taken while reset is held
  assign in_ready_o = rst_n_i && ((state_q == S_COLLECT) || (state_q == S_DROP));
  assign acc        = in_valid_i && in_ready_o;
  assign last_slot  = (wr_cnt_q == 8'(MAX_PAYLOAD - 1));
  assign data_done  = (({1'b0, rd_cnt_q} + 9'd1) == {1'b0, len_q});
  assign pad_done   = (({1'b0, rd_cnt_q} + 9'd1) >= 9'(MIN_PAYLOAD));
  assign short_pkt  = (len_q < 8'(MIN_PAYLOAD));

  assign tx_en_o   = tx_en_q;
  assign tx_data_o = tx_data_q;
  assign ovf_err_o = ovf_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= S_COLLECT;
      wr_cnt_q  <= 8'h00;
      rd_cnt_q  <= 8'h00;
      len_q     <= 8'h00;
      parity_q  <= 8'h00;
      tx_en_q   <= 1'b0;
      tx_data_q <= 8'h00;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      len_q     <= len_d;
      parity_q  <= parity_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
      ovf_q     <= ovf_d;
    end
  end

  // payload storage needs no reset; contents are only read below wr_cnt
  always_ff @(posedge clk_i) begin
    if (acc && (state_q == S_COLLECT)) buf_q[wr_cnt_q[AW-1:0]] <= in_data_i;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_COLLECT:  if (acc) begin
                    if (in_last_i)      state_d = S_SOP;
                    else if (last_slot) state_d = S_DROP;
                  end
      S_DROP:     if (acc && in_last_i) state_d = S_SOP;
      S_SOP:      state_d = S_LEN;
      S_LEN:      state_d = S_DATA;
      S_DATA:     if (data_done) state_d = short_pkt ? S_PAD : S_PARITY;
      S_PAD:      if (pad_done) state_d = S_PARITY;
      S_PARITY:   state_d = S_EOP;
      S_EOP:      state_d = S_IDLE_GAP;
      S_IDLE_GAP: state_d = S_COLLECT;
      default:    state_d = S_COLLECT;
    endcase
  end

  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    len_d     = len_q;
    parity_d  = parity_q;
    tx_en_d   = tx_en_q;
    tx_data_d = tx_data_q;
    ovf_d     = 1'b0;
    case (state_q)
      S_COLLECT: if (acc) begin
                   wr_cnt_d = wr_cnt_q + 8'd1;
                   if (in_last_i) len_d = wr_cnt_q + 8'd1;
                   else if (last_slot) begin
                     len_d = 8'(MAX_PAYLOAD);
                     ovf_d = 1'b1;
                   end
                 end
      S_SOP:     begin
                   tx_en_d   = 1'b1;
                   tx_data_d = SOP_BYTE;
                   parity_d  = 8'h00;
                 end
      S_LEN:     begin
                   tx_data_d = len_q;
                   parity_d  = parity_q ^ len_q;
                 end
      S_DATA:    begin
                   tx_data_d = buf_q[rd_cnt_q[AW-1:0]];
                   parity_d  = parity_q ^ buf_q[rd_cnt_q[AW-1:0]];
                   rd_cnt_d  = rd_cnt_q + 8'd1;
                 end
      // rd_cnt keeps counting through padding as the data-field length
      S_PAD:     begin
                   tx_data_d = PAD_BYTE;
                   parity_d  = parity_q ^ PAD_BYTE;
                   rd_cnt_d  = rd_cnt_q + 8'd1;
                 end
      S_PARITY:  tx_data_d = parity_q;
      S_EOP:     tx_data_d = EOP_BYTE;
      S_IDLE_GAP: begin
                   tx_en_d   = 1'b0;
                   tx_data_d = 8'h00;
                   wr_cnt_d  = 8'h00;
                   rd_cnt_d  = 8'h00;
                 end
      default:   ;
    endcase
  end
endmodule

// File: tb/tb_pkt_dvdr_tx_framer.sv
// Bench for pkt_dvdr_tx_framer: directed and randomized packets checked against a
// queue-based frame model; DUT built with MAX_PAYLOAD=8 so truncation is reachable.
module tb_pkt_dvdr_tx_framer;
  localparam int MAXP = 8;
  localparam int MINP = 4;

  typedef logic [7:0] bq_t [$];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       ovf_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pkt_dvdr_tx_framer #(.MAX_PAYLOAD(MAXP), .MIN_PAYLOAD(MINP)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .in_last_i(in_last), .tx_en_o(tx_en), .tx_data_o(tx_data),
    .ovf_err_o(ovf_err)
  );

  // Reference: frame = SOP, true length (capped), data, pad to MIN, XOR of len..pad, EOP
  function automatic bq_t build_frame(input bq_t p);
    bq_t f;
    int  n;
    logic [7:0] par;
    n = (p.size() > MAXP) ? MAXP : p.size();
    f.push_back(8'hA5);
    f.push_back(8'(n));
    par = 8'(n);
    for (int i = 0; i < n; i++) begin f.push_back(p[i]); par ^= p[i]; end
    for (int i = n; i < MINP; i++) f.push_back(8'h00);
    f.push_back(par);
    f.push_back(8'h5A);
    return f;
  endfunction

  function automatic bq_t ramp(input int n, input logic [7:0] first);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(first + 8'(i));
    return q;
  endfunction

  // Drive one payload; idle cycles (in_valid=0, junk data/last) precede each byte after the first.
  task automatic send_pkt(input bq_t p, input int gmin, input int gmax,
                          output int ovf_cnt, output int ovf_at, output bit ok);
    bit acc_now;
    int guard;
    ovf_cnt = 0; ovf_at = -1; ok = 1'b1;
    for (int i = 0; i < p.size(); i++) begin
      if (i > 0) begin
        int g;
        g = $urandom_range(gmax, gmin);
        for (int k = 0; k < g; k++) begin
          in_valid = 1'b0; in_data = 8'($urandom); in_last = 1'($urandom);
          @(posedge clk); #1;
          if (ovf_err) begin ovf_cnt++; ovf_at = -2; end
        end
      end
      in_valid = 1'b1; in_data = p[i]; in_last = (i == p.size() - 1);
      guard = 0;
      do begin
        acc_now = in_ready;
        @(posedge clk); #1;
        if (ovf_err) begin ovf_cnt++; ovf_at = i + 1; end
        guard++;
      end while (!acc_now && guard < 100);
      if (!acc_now) begin
        n_cmp++; n_err++;
        $display("FAIL accept_timeout byte %0d: in_ready stayed 0, required 1", i);
        ok = 1'b0;
        break;
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Called #1 after the edge that accepted the last byte.
  task automatic check_frame(input string nm, input bq_t exp);
    n_cmp++;
    if (tx_en !== 1'b0) begin
      n_err++; $display("FAIL %s gap_before_sop: tx_en=%b required 0", nm, tx_en);
    end
    for (int k = 0; k < exp.size(); k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (tx_en !== 1'b1 || tx_data !== exp[k] || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL %s byte%0d: tx_en=%b tx_data=%h in_ready=%b required 1 %h 0",
                 nm, k, tx_en, tx_data, in_ready, exp[k]);
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if (tx_en !== 1'b0 || tx_data !== 8'h00 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s after_eop: tx_en=%b tx_data=%h in_ready=%b required 0 00 1",
               nm, tx_en, tx_data, in_ready);
    end
  endtask

  task automatic run_pkt(input string nm, input bq_t p, input int gmin, input int gmax);
    int oc, oa;
    bit ok;
    send_pkt(p, gmin, gmax, oc, oa, ok);
    if (!ok) return;
    n_cmp++;
    if (p.size() > MAXP) begin
      if (oc !== 1 || oa !== MAXP) begin
        n_err++; $display("FAIL %s ovf: pulses=%0d at_byte=%0d required 1 at %0d", nm, oc, oa, MAXP);
      end
    end else if (oc !== 0) begin
      n_err++; $display("FAIL %s ovf: pulses=%0d required 0", nm, oc);
    end
    check_frame(nm, build_frame(p));
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (tx_en !== 1'b0 || tx_data !== 8'h00 || ovf_err !== 1'b0 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: tx_en=%b tx_data=%h ovf=%b in_ready=%b required 0 00 0 0",
               tx_en, tx_data, ovf_err, in_ready);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_release: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_basic;
    run_pkt("basic6", ramp(6, 8'h01), 0, 0);
  endtask

  task automatic test_pad;
    bq_t p;
    p = '{8'h10, 8'h20};
    run_pkt("pad2", p, 0, 0);
    p = '{8'h7F};
    run_pkt("single", p, 0, 0);
  endtask

  task automatic test_boundary;
    run_pkt("exact_max", ramp(MAXP, 8'h31), 0, 0);
    run_pkt("overflow10", ramp(10, 8'h01), 0, 0);
    run_pkt("exact_min", ramp(MINP, 8'hC0), 0, 0);
  endtask

  task automatic test_toggle_valid;
    run_pkt("toggle4", ramp(4, 8'h41), 1, 1);
  endtask

  task automatic test_reset_midframe;
    int oc, oa;
    bit ok;
    send_pkt(ramp(4, 8'h91), 0, 0, oc, oa, ok);
    if (!ok) return;
    @(posedge clk); #1;   // SOP on the line
    @(posedge clk); #1;   // LEN on the line
    n_cmp++;
    if (tx_en !== 1'b1 || tx_data !== 8'h04) begin
      n_err++; $display("FAIL midrst_len: tx_en=%b tx_data=%h required 1 04", tx_en, tx_data);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (tx_en !== 1'b0 || tx_data !== 8'h00 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_abort: tx_en=%b tx_data=%h in_ready=%b required 0 00 0", tx_en, tx_data, in_ready);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (tx_en !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL midrst_release: tx_en=%b in_ready=%b required 0 1", tx_en, in_ready);
    end
    run_pkt("after_rst", ramp(4, 8'hE1), 0, 0);
  endtask

  task automatic test_random;
    for (int t = 0; t < 12; t++) begin
      bq_t p;
      int n;
      n = $urandom_range(MAXP + 3, 1);
      for (int i = 0; i < n; i++) p.push_back(8'($urandom));
      run_pkt($sformatf("rand%0d_len%0d", t, n), p, 0, 2);
    end
  endtask

  task automatic test_back_to_back;
    run_pkt("b2b_a", ramp(5, 8'h21), 0, 0);
    run_pkt("b2b_b", ramp(3, 8'h61), 0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pad();
    test_boundary();
    test_toggle_valid();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end
endmodule
